// File: rtl/grid_vga_render.sv
// grid_vga_render: renders a 16x16 occupancy grid onto a 640x480 VGA raster.
//   clk        : system clock (pixel rate is clk/4 via a 2-bit divider)
//   reset      : asynchronous, active-low
//   enable     : when low the divider, counters and outputs hold
//   grid_in    : 256-bit occupancy, cell (row r, col c) at bit c*16+r
//   hsync      : horizontal sync, active-low, registered
//   vsync      : vertical sync, active-low, registered
//   rgb        : {R,G,B} 4 bits each, registered
//   frame_tick : one-clk pulse on the clk where grid_in is snapshotted
// Raster geometry is parameterised; the defaults give standard 640x480@60.
// Optional macro GRID_LINES_EN draws 12'h444 lines at sub-cell offset 0.
module grid_vga_render #(
  parameter int unsigned CELL_PX      = 24,
  parameter int unsigned X_OFFSET     = 128,
  parameter int unsigned Y_OFFSET     = 48,
  parameter logic [11:0] FILL_RGB     = 12'hF80,
  parameter logic [11:0] EMPTY_RGB    = 12'h112,
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_SYNC_START = 656,
  parameter int unsigned H_SYNC_END   = 752,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_SYNC_START = 490,
  parameter int unsigned V_SYNC_END   = 492,
  parameter int unsigned V_TOTAL      = 525
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [255:0] grid_in,
  output logic         hsync,
  output logic         vsync,
  output logic [11:0]  rgb,
  output logic         frame_tick
);

  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned SW       = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int unsigned FIELD_PX = 16 * CELL_PX;

  logic [1:0]    div_q, div_d;
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [SW-1:0] hsub_q, hsub_d, vsub_q, vsub_d;
  logic [3:0]    col_q, col_d, row_q, row_d;
  logic [255:0]  fb_q, fb_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic [11:0]   rgb_q, rgb_d;

  logic          pix_tick, line_end, frame_end, snap;
  logic          in_vis, in_field;
  logic [11:0]   cell_rgb;
  int unsigned   h_int, v_int;

  always_comb begin
    h_int     = 32'(hcount_q);
    v_int     = 32'(vcount_q);
    pix_tick  = enable && (div_q == 2'd3);
    line_end  = (h_int == H_TOTAL - 1);
    frame_end = (v_int == V_TOTAL - 1);
    snap      = pix_tick && (h_int == 0) && (v_int == V_VISIBLE);
    in_vis    = (h_int < H_VISIBLE) && (v_int < V_VISIBLE);
    in_field  = (h_int >= X_OFFSET) && (h_int < X_OFFSET + FIELD_PX) &&
                (v_int >= Y_OFFSET) && (v_int < Y_OFFSET + FIELD_PX);
    cell_rgb  = fb_q[{col_q, row_q}] ? FILL_RGB : EMPTY_RGB;
`ifdef GRID_LINES_EN
    if ((hsub_q == '0) || (vsub_q == '0)) cell_rgb = 12'h444;
`endif
  end

  always_comb begin
    div_d    = div_q;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    hsub_d   = hsub_q;
    vsub_d   = vsub_q;
    col_d    = col_q;
    row_d    = row_q;
    fb_d     = fb_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    rgb_d    = rgb_q;
    if (enable) div_d = div_q + 2'd1;
    if (pix_tick) begin
      hcount_d = line_end ? '0 : hcount_q + 1'b1;
      // Sub-cell counters resynchronise when the raster enters the field, so
      // their values outside the field are don't-care.
      if (32'(hcount_d) == X_OFFSET) begin
        hsub_d = '0;
        col_d  = '0;
      end else if (32'(hsub_q) == CELL_PX - 1) begin
        hsub_d = '0;
        col_d  = col_q + 4'd1;
      end else begin
        hsub_d = hsub_q + 1'b1;
      end
      if (line_end) begin
        vcount_d = frame_end ? '0 : vcount_q + 1'b1;
        if (32'(vcount_d) == Y_OFFSET) begin
          vsub_d = '0;
          row_d  = '0;
        end else if (32'(vsub_q) == CELL_PX - 1) begin
          vsub_d = '0;
          row_d  = row_q + 4'd1;
        end else begin
          vsub_d = vsub_q + 1'b1;
        end
      end
      // Outputs describe the pixel the counters held before this tick.
      hsync_d = !((h_int >= H_SYNC_START) && (h_int < H_SYNC_END));
      vsync_d = !((v_int >= V_SYNC_START) && (v_int < V_SYNC_END));
      rgb_d   = (in_vis && in_field) ? cell_rgb : '0;
      if (snap) fb_d = grid_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q    <= '0;
      hcount_q <= '0;
      vcount_q <= '0;
      hsub_q   <= '0;
      vsub_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      fb_q     <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      rgb_q    <= '0;
    end else begin
      div_q    <= div_d;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsub_q   <= hsub_d;
      vsub_q   <= vsub_d;
      col_q    <= col_d;
      row_q    <= row_d;
      fb_q     <= fb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      rgb_q    <= rgb_d;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign rgb        = rgb_q;
  assign frame_tick = snap;

endmodule

// File: tb/tb_grid_vga_render.sv
// Scoreboard bench for grid_vga_render on a shrunken raster (50x40 ticks,
// 2-pixel cells) so several complete frames fit in a short run.
module tb_grid_vga_render;

  localparam int CP  = 2;
  localparam int XO  = 4;
  localparam int YO  = 2;
  localparam int HV  = 40;
  localparam int HSS = 42;
  localparam int HSE = 48;
  localparam int HT  = 50;
  localparam int VV  = 36;
  localparam int VSS = 37;
  localparam int VSE = 39;
  localparam int VT  = 40;
  localparam logic [11:0] FILL  = 12'hF80;
  localparam logic [11:0] EMPTY = 12'h112;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic [255:0] grid_in = '0;
  logic         hsync, vsync, frame_tick;
  logic [11:0]  rgb;

  grid_vga_render #(
    .CELL_PX(CP), .X_OFFSET(XO), .Y_OFFSET(YO),
    .FILL_RGB(FILL), .EMPTY_RGB(EMPTY),
    .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .grid_in(grid_in),
    .hsync(hsync), .vsync(vsync), .rgb(rgb), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } out_t;

  typedef struct {
    out_t o;
    int   h;
    int   v;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   mdiv = 0, mh = 0, mv = 0;
  logic [255:0] mfb = '0;
  int   ft_count = 0;

  function automatic out_t model_out(input int h, input int v, input logic [255:0] fb);
    out_t o;
    int c, r;
    o.hs  = !(h >= HSS && h < HSE);
    o.vs  = !(v >= VSS && v < VSE);
    o.rgb = 12'h000;
    if (h < HV && v < VV && h >= XO && h < XO + 16*CP && v >= YO && v < YO + 16*CP) begin
      c = (h - XO) / CP;
      r = (v - YO) / CP;
      o.rgb = fb[c*16 + r] ? FILL : EMPTY;
`ifdef GRID_LINES_EN
      if (((h - XO) % CP == 0) || ((v - YO) % CP == 0)) o.rgb = 12'h444;
`endif
    end
    return o;
  endfunction

  // Reference model: pushes the expected registered outputs at every pixel tick.
  always @(posedge clk or negedge reset) begin
    exp_t e;
    if (!reset) begin
      mdiv = 0; mh = 0; mv = 0; mfb = '0;
      sb.delete();
      e.o = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};
      e.h = -1; e.v = -1;
      sb.push_back(e);
    end else if (enable) begin
      if (mdiv == 3) begin
        e.o = model_out(mh, mv, mfb);
        e.h = mh; e.v = mv;
        sb.push_back(e);
        if (mh == 0 && mv == VV) mfb = grid_in;
        mh++;
        if (mh == HT) begin
          mh = 0;
          mv++;
          if (mv == VT) mv = 0;
        end
      end
      mdiv = (mdiv + 1) % 4;
    end
  end

  // Monitor: outputs must equal the most recent expectation on every clk
  // (this also covers holding while enable is low).
  out_t cur;
  bit   have_cur = 1'b0;
  int   cur_h = 0, cur_v = 0;
  logic ft_exp;

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cur = e.o; cur_h = e.h; cur_v = e.v;
      have_cur = 1'b1;
    end
    if (have_cur) begin
      vectors++;
      if ({hsync, vsync, rgb} !== cur) begin
        miscompares++;
        $display("FAIL pixel h=%0d v=%0d: got hs=%b vs=%b rgb=%h, want hs=%b vs=%b rgb=%h",
                 cur_h, cur_v, hsync, vsync, rgb, cur.hs, cur.vs, cur.rgb);
      end
    end
    ft_exp = reset && enable && (mdiv == 3) && (mh == 0) && (mv == VV);
    vectors++;
    if (frame_tick !== ft_exp) begin
      miscompares++;
      $display("FAIL frame_tick at h=%0d v=%0d: got %b, want %b", mh, mv, frame_tick, ft_exp);
    end
    if (frame_tick === 1'b1) ft_count++;
  end

  // Advance until the model raster is at (v,h); inputs then change 2 time units after the edge.
  task automatic wait_at(input int v, input int h);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n > 20000) begin
        vectors++;
        miscompares++;
        $display("FAIL timeout waiting for v=%0d h=%0d: at v=%0d h=%0d", v, h, mv, mh);
        return;
      end
    end while (!(mv == v && mh == h));
    #1;
  endtask

  initial begin
    logic [255:0] b0, b255;
    b0 = '0;   b0[0] = 1'b1;
    b255 = '0; b255[255] = 1'b1;
    reset = 1'b0;
    enable = 1'b1;
    grid_in = b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;

    // Frame 0 renders all-empty; its snapshot loads cell (0,0).
    wait_at(VV, 5);
    // Mid-line freeze of 37 clk in frame 1.
    wait_at(10, 20);
    enable = 1'b0;
    repeat (37) @(posedge clk);
    #2 enable = 1'b1;
    // Cell (15,15) added mid-frame: must not appear until the next snapshot.
    wait_at(20, 0);
    grid_in = b0 | b255;
    wait_at(VV, 5);
    wait_at(15, 0);
    grid_in = '1;
    wait_at(VV, 5);
    // Reset mid-frame 3, then run into the following frame.
    wait_at(20, 10);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    wait_at(VV, 5);
    wait_at(5, 0);
    repeat (4) @(posedge clk);

    // Snapshots: end of frames 0, 1, 2 and of the frame started after reset.
    vectors++;
    if (ft_count != 4) begin
      miscompares++;
      $display("FAIL frame_tick count: got %0d, want 4", ft_count);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/grid_vga_render.md
GRID_VGA_RENDER -- requirements
Module: grid_vga_render

Interface
REQ-001 Parameter CELL_PX, default 24: pixel edge length of one square grid cell.
REQ-002 Parameter X_OFFSET, default 128: first visible column of the play field, in pixels.
REQ-003 Parameter Y_OFFSET, default 48: first visible row of the play field, in pixels.
REQ-004 Parameter FILL_RGB, default 12'hF80: colour of occupied cells.
REQ-005 Parameter EMPTY_RGB, default 12'h112: colour of empty cells inside the field.
REQ-006 Port clk, input, 1 bit: 100 MHz system clock; the block's only clock.
REQ-007 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port enable, input, 1 bit: when low, the pixel divider and all counters hold.
REQ-009 Port grid_in, input, 256 bits: occupancy from the grid stage; cell (row r, col c) is bit c*16+r.
REQ-010 Port hsync, output, 1 bit: horizontal sync, active-low.
REQ-011 Port vsync, output, 1 bit: vertical sync, active-low.
REQ-012 Port rgb, output, 12 bits: pixel colour {R[3:0],G[3:0],B[3:0]}.
REQ-013 Port frame_tick, output, 1 bit: one-clk pulse when grid_in is snapshotted.

Function
REQ-014 A free-running 2-bit divider SHALL advance on each clk while enable is high; the pixel tick is asserted when the divider equals 3 (25 MHz).
REQ-015 On each pixel tick, hcount SHALL step 0..799 and wrap to 0; vcount SHALL step 0..524 when hcount wraps, and wrap to 0 after 524.
REQ-016 Timing SHALL be 640x480: horizontal visible 0-639, sync 656-751; vertical visible 0-479, sync 490-491.
REQ-017 The pixel at (hcount,vcount) is in the field when X_OFFSET <= h < X_OFFSET+16*CELL_PX and Y_OFFSET <= v < Y_OFFSET+16*CELL_PX.
REQ-018 Cell column and row SHALL be derived from incremental sub-cell counters, with no divider; col = (h-X_OFFSET)/CELL_PX and row = (v-Y_OFFSET)/CELL_PX.
REQ-019 rgb SHALL be FILL_RGB if the cell's bit in the frame buffer is 1, otherwise EMPTY_RGB.
REQ-020 rgb SHALL be 0 for visible pixels outside the field and for all non-visible pixels.
REQ-021 hsync, vsync and rgb SHALL be registered and mutually aligned, updating on the pixel tick one tick after the counters reach the pixel (latency 1 pixel = 4 clk).
REQ-022 On the pixel tick where hcount=0 and vcount=480, a 256-bit frame buffer SHALL load grid_in and frame_tick SHALL pulse for exactly that clk.
REQ-023 The frame buffer SHALL NOT change at any other time, so grid_in changes mid-frame never tear the displayed image.
REQ-024 When enable is deasserted, all outputs SHALL hold their values and frame_tick SHALL be 0.

Reset
REQ-025 While reset=0, the divider, hcount, vcount and frame buffer SHALL clear to 0.
REQ-026 While reset=0, outputs SHALL be rgb=0, hsync=1, vsync=1 and frame_tick=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame; after release, scanning restarts at (0,0) on the 4th enabled clk.
REQ-028 Until the first snapshot after reset, all in-field pixels SHALL render EMPTY_RGB.

Configuration
REQ-029 With macro GRID_LINES_EN defined, in-field pixels at sub-cell offset 0 in x or y SHALL render 12'h444, overriding cell colour.
REQ-030 With GRID_LINES_EN undefined, no grid lines SHALL be drawn and the related logic SHALL be absent.

Verification
REQ-031 Reset release, enable=1, one full frame -> hsync low for exactly 96 ticks per line; vsync low for lines 490-491; 800x525 ticks per frame.
REQ-032 grid_in=0 except bit 0 -> rgb=FILL_RGB only for h 128-151, v 48-71 (plus 1-tick latency); other in-field pixels EMPTY_RGB.
REQ-033 Set bit 255 at vcount=200, after a snapshot -> no change until the frame_tick at (0,480); next frame shows h 488-511, v 408-431 filled.
REQ-034 grid_in all ones, GRID_LINES_EN defined -> rgb=12'h444 at h=128,152,... and v=48,72,...; FILL_RGB elsewhere in the field; 0 at h=600.
REQ-035 Drop enable for 37 clk mid-line -> counters and outputs freeze, then resume with no skipped pixel.
REQ-036 Assert reset at vcount=300 -> outputs go to reset values immediately; after release, frame_tick next pulses at vcount=480 of the new frame.
